// File: rtl/keypad_scanner.sv
// Matrix keypad scanner: one-hot column drive, per-key frame debounce and an
// event FIFO (press codes, optionally release codes) with a valid/ready head.
module keypad_scanner #(
    parameter int CLK_HZ         = 27_000_000,
    parameter int SCAN_US        = 1000,
    parameter int ROWS           = 4,
    parameter int COLS           = 4,
    parameter int DEBOUNCE_SCANS = 2,
    parameter int FIFO_DEPTH     = 4,
    parameter int REPORT_RELEASE = 0,
    localparam int CODE_W        = (ROWS * COLS > 1) ? $clog2(ROWS * COLS) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ROWS-1:0]   rows_in,
    output logic [COLS-1:0]   cols_out,
    output logic [CODE_W-1:0] key_code,
    output logic              key_release,
    output logic              key_valid,
    input  logic              key_ready,
    output logic              key_held,
    output logic              overflow,
    input  logic              clr_overflow
);
    localparam int TICKS = CLK_HZ / 1_000_000 * SCAN_US;
    localparam int NKEYS = ROWS * COLS;
    localparam int CNT_W = (TICKS > 1) ? $clog2(TICKS) : 1;
    localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int DC_W  = (DEBOUNCE_SCANS > 1) ? $clog2(DEBOUNCE_SCANS) : 1;
    localparam int PTR_W = $clog2(FIFO_DEPTH);

    localparam logic [CNT_W-1:0] SNAP_AT   = CNT_W'(TICKS - ROWS - 1);
    localparam logic [CNT_W-1:0] EVAL_BASE = CNT_W'(TICKS - ROWS);
    localparam logic [CNT_W-1:0] LAST_TICK = CNT_W'(TICKS - 1);
    localparam logic [COL_W-1:0] LAST_COL  = COL_W'(COLS - 1);
    localparam logic [DC_W-1:0]  DC_LAST   = DC_W'(DEBOUNCE_SCANS - 1);

    generate
        if (TICKS < ROWS + 2) begin : g_bad_ticks
            $error("keypad_scanner: TICKS must be at least ROWS+2");
        end
    endgenerate

    typedef enum logic {SETTLE, EVAL} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [COL_W-1:0]   col_q, col_d;
    logic [ROWS-1:0]    rows_meta_q, rows_sync_q, snap_q, rows_by_index;
    logic               snap_load, eval_en;
    logic [NKEYS-1:0]   stable_q;
    logic [DC_W-1:0]    dcnt_q [NKEYS];
    logic               key_held_q, overflow_q;

    // Snapshot is stored with bit r = logical row r so the evaluator indexes directly.
    for (genvar gi = 0; gi < ROWS; gi++) begin : g_row_map
        assign rows_by_index[gi] = rows_sync_q[ROWS-1-gi];
    end
    for (genvar gi = 0; gi < COLS; gi++) begin : g_col_drive
        assign cols_out[COLS-1-gi] = (col_q == COL_W'(gi));
    end

    always_comb begin
        state_d   = state_q;
        count_d   = count_q + 1'b1;
        col_d     = col_q;
        snap_load = 1'b0;
        eval_en   = 1'b0;
        case (state_q)
            SETTLE: begin
                if (count_q == SNAP_AT) begin
                    snap_load = 1'b1;
                    state_d   = EVAL;
                end
            end
            EVAL: begin
                eval_en = 1'b1;
                if (count_q == LAST_TICK) begin
                    count_d = '0;
                    col_d   = (col_q == LAST_COL) ? '0 : col_q + 1'b1;
                    state_d = SETTLE;
                end
            end
            default: state_d = SETTLE;
        endcase
    end

    logic [ROW_W-1:0]  row_idx;
    logic [CODE_W-1:0] key_idx;
    logic              sample, cur_stable, flip, push_en;
    logic [DC_W-1:0]   cur_cnt;

    assign row_idx    = ROW_W'(count_q - EVAL_BASE);
    assign key_idx    = CODE_W'(row_idx) * CODE_W'(COLS) + CODE_W'(col_q);
    assign sample     = snap_q[row_idx];
    assign cur_stable = stable_q[key_idx];
    assign cur_cnt    = dcnt_q[key_idx];
    assign flip       = eval_en && (sample != cur_stable) && (cur_cnt == DC_LAST);
    assign push_en    = flip && (sample || (REPORT_RELEASE != 0));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= SETTLE;
            count_q     <= '0;
            col_q       <= '0;
            rows_meta_q <= '0;
            rows_sync_q <= '0;
            snap_q      <= '0;
            stable_q    <= '0;
            key_held_q  <= 1'b0;
            for (int k = 0; k < NKEYS; k++) dcnt_q[k] <= '0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            col_q       <= col_d;
            rows_meta_q <= rows_in;
            rows_sync_q <= rows_meta_q;
            key_held_q  <= |stable_q;
            if (snap_load) snap_q <= rows_by_index;
            if (eval_en) begin
                if (sample == cur_stable) begin
                    dcnt_q[key_idx] <= '0;
                end else if (flip) begin
                    stable_q[key_idx] <= sample;
                    dcnt_q[key_idx]   <= '0;
                end else begin
                    dcnt_q[key_idx] <= cur_cnt + 1'b1;
                end
            end
        end
    end

    // Event FIFO: pointers carry one wrap bit to tell full from empty.
    logic [CODE_W-1:0] mem_code [FIFO_DEPTH];
    logic              mem_rel  [FIFO_DEPTH];
    logic [PTR_W:0]    wr_ptr_q, rd_ptr_q;
    logic              fifo_empty, fifo_full, pop, push_ok, drop;

    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                        (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    assign pop        = !fifo_empty && key_ready;
    assign push_ok    = push_en && (!fifo_full || pop);
    assign drop       = push_en && fifo_full && !pop;

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_code[wr_ptr_q[PTR_W-1:0]] <= key_idx;
            mem_rel[wr_ptr_q[PTR_W-1:0]]  <= !sample;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
            if (drop)              overflow_q <= 1'b1;
            else if (clr_overflow) overflow_q <= 1'b0;
        end
    end

    assign key_valid   = !fifo_empty;
    assign key_code    = fifo_empty ? '0 : mem_code[rd_ptr_q[PTR_W-1:0]];
    assign key_release = fifo_empty ? 1'b0 : mem_rel[rd_ptr_q[PTR_W-1:0]];
    assign key_held    = key_held_q;
    assign overflow    = overflow_q;
endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: a physical key-matrix model drives two instances
// (release reporting off/on); events are checked against a frame-level debounce model.
module tb_keypad_scanner;
    localparam int ROWS = 4;
    localparam int COLS = 4;
    localparam int DS   = 2;
    localparam int CW   = 4;
    localparam int FRAME = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic key_ready = 1'b0;
    logic clr = 1'b0;
    logic keys [ROWS][COLS];

    logic [ROWS-1:0] rows0, rows1;
    logic [COLS-1:0] cols0, cols1;
    logic [CW-1:0]   code0, code1;
    logic rel0, rel1, v0, v1, held0, held1, ovf0, ovf1;

    keypad_scanner #(.CLK_HZ(1_000_000), .SCAN_US(8), .ROWS(ROWS), .COLS(COLS),
                     .DEBOUNCE_SCANS(DS), .FIFO_DEPTH(4), .REPORT_RELEASE(0)) u_dut0 (
        .clk(clk), .reset(rst), .rows_in(rows0), .cols_out(cols0), .key_code(code0),
        .key_release(rel0), .key_valid(v0), .key_ready(key_ready), .key_held(held0),
        .overflow(ovf0), .clr_overflow(clr));

    keypad_scanner #(.CLK_HZ(1_000_000), .SCAN_US(8), .ROWS(ROWS), .COLS(COLS),
                     .DEBOUNCE_SCANS(DS), .FIFO_DEPTH(4), .REPORT_RELEASE(1)) u_dut1 (
        .clk(clk), .reset(rst), .rows_in(rows1), .cols_out(cols1), .key_code(code1),
        .key_release(rel1), .key_valid(v1), .key_ready(key_ready), .key_held(held1),
        .overflow(ovf1), .clr_overflow(clr));

    always #5 clk = ~clk;

    // A pressed key shorts its row line to its driven column.
    always_comb begin
        rows0 = '0;
        rows1 = '0;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) begin
                if (keys[r][c] && cols0[COLS-1-c]) rows0[ROWS-1-r] = 1'b1;
                if (keys[r][c] && cols1[COLS-1-c]) rows1[ROWS-1-r] = 1'b1;
            end
    end

    logic [CW:0] got0[$], got1[$], exp0[$], exp1[$];

    always @(negedge clk) begin
        if (v0 && key_ready) got0.push_back({rel0, code0});
        if (v1 && key_ready) got1.push_back({rel1, code1});
    end

    int tests = 0;
    int fails = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: one sample per key per frame; DS consecutive contrary samples flip it.
    logic st_m [ROWS*COLS];
    int   cnt_m [ROWS*COLS];

    function automatic logic any_stable();
        logic a = 1'b0;
        for (int k = 0; k < ROWS*COLS; k++) a |= st_m[k];
        return a;
    endfunction

    task automatic model_frame();
        for (int c = 0; c < COLS; c++)
            for (int r = 0; r < ROWS; r++) begin
                int k = r * COLS + c;
                if (keys[r][c] == st_m[k]) cnt_m[k] = 0;
                else begin
                    cnt_m[k]++;
                    if (cnt_m[k] == DS) begin
                        st_m[k]  = keys[r][c];
                        cnt_m[k] = 0;
                        if (keys[r][c]) begin
                            exp0.push_back({1'b0, CW'(k)});
                            exp1.push_back({1'b0, CW'(k)});
                        end else begin
                            exp1.push_back({1'b1, CW'(k)});
                        end
                    end
                end
            end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_all();
        got0.delete(); got1.delete(); exp0.delete(); exp1.delete();
        for (int k = 0; k < ROWS*COLS; k++) begin st_m[k] = 1'b0; cnt_m[k] = 0; end
    endtask

    task automatic set_keys_zero();
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) keys[r][c] = 1'b0;
    endtask

    // Leaves the DUTs at tick 0 of column 0 with reset released.
    task automatic do_reset();
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        clear_all();
    endtask

    task automatic run_frame();
        tick(2);
        check("held", held0, any_stable());
        model_frame();
        tick(FRAME - 2);
    endtask

    task automatic pop_one();
        key_ready = 1'b1;
        tick(1);
        key_ready = 1'b0;
    endtask

    initial begin
        int codes [5] = '{1, 2, 3, 5, 7};
        int exp_fifo [4] = '{1, 2, 3, 5};
        set_keys_zero();
        clear_all();

        // Reset state and column rotation
        do_reset();
        check("rst_cols", cols0, 4'b1000);
        check("rst_valid", v0, 0);
        check("rst_code", code0, 0);
        check("rst_rel", rel0, 0);
        check("rst_held", held0, 0);
        check("rst_ovf", ovf0, 0);
        tick(8);
        check("col1", cols0, 4'b0100);
        tick(24);
        check("col_wrap", cols0, 4'b1000);
        check("idle_valid", v0, 0);

        // Held key row1/col2: one press, no repeat
        do_reset();
        key_ready = 1'b1;
        keys[1][2] = 1'b1;
        repeat (3) run_frame();
        check("hold_n", got0.size(), 1);
        if (got0.size() > 0) check("hold_evt", got0[0], {1'b0, 4'd6});
        check("hold_held", held0, 1);
        repeat (3) run_frame();
        check("hold_norep", got0.size(), 1);
        set_keys_zero();

        // One-frame glitch
        do_reset();
        keys[1][2] = 1'b1;
        run_frame();
        set_keys_zero();
        repeat (3) run_frame();
        check("glitch_n", got0.size(), 0);
        check("glitch_held", held0, 0);

        // Two keys of column 0 in the same frame, consumer stalled
        do_reset();
        key_ready = 1'b0;
        keys[0][0] = 1'b1;
        keys[3][0] = 1'b1;
        repeat (3) run_frame();
        check("two_valid", v0, 1);
        check("two_head0", code0, 0);
        pop_one();
        check("two_head1", code0, 12);
        check("two_rel1", rel0, 0);
        pop_one();
        check("two_empty", v0, 0);
        set_keys_zero();

        // Overflow with five presses into a four-deep queue
        do_reset();
        key_ready = 1'b0;
        foreach (codes[i]) begin
            keys[codes[i] / COLS][codes[i] % COLS] = 1'b1;
            repeat (3) run_frame();
        end
        check("ovf_set", ovf0, 1);
        clr = 1'b1;
        tick(1);
        clr = 1'b0;
        check("ovf_clr", ovf0, 0);
        foreach (exp_fifo[i]) begin
            check("ovf_valid", v0, 1);
            check("ovf_code", code0, exp_fifo[i]);
            pop_one();
        end
        check("ovf_empty", v0, 0);
        set_keys_zero();

        // Release reporting, then reset while held
        do_reset();
        key_ready = 1'b1;
        keys[1][2] = 1'b1;
        repeat (3) run_frame();
        keys[1][2] = 1'b0;
        repeat (3) run_frame();
        check("rr_n1", got1.size(), 2);
        if (got1.size() == 2) begin
            check("rr_press", got1[0], {1'b0, 4'd6});
            check("rr_release", got1[1], {1'b1, 4'd6});
        end
        check("rr_n0", got0.size(), 1);
        clear_all();
        key_ready = 1'b0;
        keys[1][2] = 1'b1;
        repeat (3) run_frame();
        check("rr_queued", v1, 1);
        rst = 1'b1;
        tick(1);
        check("rr_rst_v1", v1, 0);
        check("rr_rst_v0", v0, 0);
        rst = 1'b0;
        clear_all();
        key_ready = 1'b1;
        repeat (3) run_frame();
        check("rr_again_n", got1.size(), 1);
        if (got1.size() > 0) check("rr_again", got1[0], {1'b0, 4'd6});
        set_keys_zero();

        // Randomised key activity against the frame model
        do_reset();
        key_ready = 1'b1;
        for (int f = 0; f < 40; f++) begin
            for (int r = 0; r < ROWS; r++)
                for (int c = 0; c < COLS; c++)
                    if ($urandom_range(3) == 0) keys[r][c] = ~keys[r][c];
            run_frame();
        end
        set_keys_zero();
        repeat (4) run_frame();
        check("rnd_n0", got0.size(), exp0.size());
        check("rnd_n1", got1.size(), exp1.size());
        for (int i = 0; i < got0.size() && i < exp0.size(); i++) check("rnd_evt0", got0[i], exp0[i]);
        for (int i = 0; i < got1.size() && i < exp1.size(); i++) check("rnd_evt1", got1[i], exp1[i]);
        check("rnd_ovf", ovf0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
